// File: rtl/sorter_pkg.sv
// Shared helpers for the sliding-window rank sorter: width math and the
// median index, available both as functions and as default-window constants.
package sorter_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  function automatic int med_idx(input int w);
    return (w - 1) / 2;
  endfunction

  function automatic int rank_w(input int w);
    return (w < 2) ? 1 : clog2(w);
  endfunction

  localparam int DEF_WINDOW = 7;
  localparam int MED_IDX    = med_idx(DEF_WINDOW);
  localparam int RANK_W     = rank_w(DEF_WINDOW);

endpackage

// File: rtl/sorter_rank.sv
// Rank of element IDX within the window: smaller elements plus equal
// elements at a lower index, so equal values get distinct, stable ranks.
module sorter_rank
  import sorter_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int WINDOW     = DEF_WINDOW,
  parameter int IDX        = 0,
  parameter int RW         = rank_w(WINDOW)
) (
  input  logic [WINDOW-1:0][DATA_WIDTH-1:0] win,
  output logic [RW-1:0]                     rank
);

  int cnt;

  always_comb begin
    cnt = 0;
    for (int j = 0; j < WINDOW; j++) begin
      if ((win[j] < win[IDX]) || ((j < IDX) && (win[j] == win[IDX])))
        cnt = cnt + 1;
    end
    rank = RW'(cnt);
  end

endmodule

// File: rtl/window_sorter.sv
// Sliding-window sorter: window register -> per-element rank -> min/med/max
// select with impulse-noise flag. Three valid stages, whole pipe holds on stall.
module window_sorter
  import sorter_pkg::*;
#(
  parameter int          DATA_WIDTH = 8,
  parameter int          WINDOW     = DEF_WINDOW,
  parameter int unsigned THRESHOLD  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_min,
  output logic [DATA_WIDTH-1:0] out_med,
  output logic [DATA_WIDTH-1:0] out_max,
  output logic [DATA_WIDTH-1:0] out_center,
  output logic                  out_noise,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int MED = med_idx(WINDOW);
  localparam int RW  = rank_w(WINDOW);
  localparam int CW  = clog2(WINDOW + 1);
  localparam logic [DATA_WIDTH:0] TH = (DATA_WIDTH + 1)'(THRESHOLD);

  logic [WINDOW-1:0][DATA_WIDTH-1:0] win, s2_win;
  logic [WINDOW-1:0][RW-1:0]         rank, s2_rank;
  logic [CW-1:0]                     fill;
  logic [2:0]                        vld_pipe;
  logic                              stall, accept, launch;

  logic [DATA_WIDTH-1:0] sel_min, sel_med, sel_max, sel_ctr;
  logic [DATA_WIDTH:0]   diff;
  logic                  sel_noise;

  assign out_valid = vld_pipe[2];
  assign stall     = vld_pipe[2] && !out_ready;
  assign in_ready  = !stall && !flush;
  assign accept    = in_valid && in_ready;
  // Launch when this acceptance leaves the fill counter at WINDOW.
  assign launch    = accept && (fill >= CW'(WINDOW - 1));

  for (genvar i = 0; i < WINDOW; i++) begin : g_rank
    sorter_rank #(
      .DATA_WIDTH (DATA_WIDTH),
      .WINDOW     (WINDOW),
      .IDX        (i),
      .RW         (RW)
    ) u_rank (
      .win  (win),
      .rank (rank[i])
    );
  end

  always_comb begin
    sel_min = '0;
    sel_med = '0;
    sel_max = '0;
    for (int i = 0; i < WINDOW; i++) begin
      if (s2_rank[i] == RW'(0))          sel_min = s2_win[i];
      if (s2_rank[i] == RW'(MED))        sel_med = s2_win[i];
      if (s2_rank[i] == RW'(WINDOW - 1)) sel_max = s2_win[i];
    end
    sel_ctr   = s2_win[MED];
    diff      = (sel_ctr >= sel_med) ? ({1'b0, sel_ctr} - {1'b0, sel_med})
                                     : ({1'b0, sel_med} - {1'b0, sel_ctr});
    sel_noise = diff > TH;
  end

  // Data path: no reset needed, contents are qualified by vld_pipe.
  always_ff @(posedge clk) begin
    if (accept) win <= {win[WINDOW-2:0], in_data};
    if (!stall) begin
      s2_win  <= win;
      s2_rank <= rank;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fill       <= '0;
      vld_pipe   <= '0;
      out_min    <= '0;
      out_med    <= '0;
      out_max    <= '0;
      out_center <= '0;
      out_noise  <= 1'b0;
    end else if (flush) begin
      fill     <= '0;
      vld_pipe <= '0;
    end else if (!stall) begin
      vld_pipe <= {vld_pipe[1:0], launch};
      if (accept && (fill != CW'(WINDOW))) fill <= fill + 1'b1;
      if (vld_pipe[1]) begin
        out_min    <= sel_min;
        out_med    <= sel_med;
        out_max    <= sel_max;
        out_center <= sel_ctr;
        out_noise  <= sel_noise;
      end
    end
  end

endmodule

// File: tb/tb_window_sorter.sv
// Bench for window_sorter: hand vectors and a sorting reference model feed a
// scoreboard queue that is checked whenever out_valid is high.
module tb_window_sorter;

  localparam int DW = 8;
  localparam int W  = 7;
  localparam int TH = 32;

  typedef struct packed {
    logic [DW-1:0] mn, md, mx, ct;
    logic          nz;
  } exp_t;

  typedef struct {
    logic [DW-1:0] s [W];
    exp_t          e;
  } vec_t;

  logic          clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 1;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_noise, out_valid;
  logic [DW-1:0] out_min, out_med, out_max, out_center;

  int   checks = 0, errors = 0, stall_seen = 0, fill_m = 0;
  logic [DW-1:0] mw [W];
  exp_t q[$];
  bit   tbl_mode = 0;
  exp_t tbl_exp;
  vec_t tbl [10];

  window_sorter #(.DATA_WIDTH(DW), .WINDOW(W), .THRESHOLD(TH)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .out_min(out_min), .out_med(out_med), .out_max(out_max),
    .out_center(out_center), .out_noise(out_noise), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic exp_t model_exp();
    logic [DW-1:0] a [W];
    logic [DW-1:0] t;
    exp_t e;
    int d;
    for (int i = 0; i < W; i++) a[i] = mw[i];
    for (int i = 0; i < W; i++)
      for (int j = 0; j < W - 1 - i; j++)
        if (a[j] > a[j+1]) begin t = a[j]; a[j] = a[j+1]; a[j+1] = t; end
    e.mn = a[0]; e.md = a[(W-1)/2]; e.mx = a[W-1]; e.ct = mw[(W-1)/2];
    d = int'(e.ct) - int'(e.md);
    if (d < 0) d = -d;
    e.nz = d > TH;
    return e;
  endfunction

  // Reference window tracking and scoreboard push on every acceptance.
  always @(posedge clk) begin
    if (rst || flush) begin
      fill_m = 0;
      q.delete();
    end else if (in_valid && in_ready) begin
      for (int k = W - 1; k > 0; k--) mw[k] = mw[k-1];
      mw[0] = in_data;
      if (fill_m < W) fill_m++;
      if (fill_m == W) q.push_back(tbl_mode ? tbl_exp : model_exp());
    end
  end

  always @(negedge clk) begin
    exp_t got;
    if (!rst && out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL spurious_out: out_valid=1 with no expected result pending");
      end else begin
        got = '{out_min, out_med, out_max, out_center, out_noise};
        if (got !== q[0]) begin
          errors++;
          $display("FAIL result: got min=%0d med=%0d max=%0d ctr=%0d nz=%0b, want min=%0d med=%0d max=%0d ctr=%0d nz=%0b",
                   got.mn, got.md, got.mx, got.ct, got.nz, q[0].mn, q[0].md, q[0].mx, q[0].ct, q[0].nz);
        end
        if (out_ready) void'(q.pop_front());
      end
      if (!out_ready) begin
        stall_seen++;
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL stall_ready: in_ready=%0b want 0", in_ready);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  task automatic send(input logic [DW-1:0] d);
    bit ok;
    ok = 0;
    in_valid = 1; in_data = d;
    for (int k = 0; k < 50 && !ok; k++) begin
      @(negedge clk); ok = in_ready;
      @(posedge clk);
    end
    #1 in_valid = 0;
    if (!ok) begin
      checks++; errors++;
      $display("FAIL send_timeout: sample %0d never accepted", d);
    end
  endtask

  task automatic pulse_flush();
    flush = 1; in_valid = 1; in_data = 8'd99;
    @(negedge clk);
    chk("flush_in_ready", 64'(in_ready), 0);
    @(posedge clk);
    #1 flush = 0; in_valid = 0;
    @(negedge clk);
    chk("flush_out_valid", 64'(out_valid), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 60 && q.size() != 0; i++) @(posedge clk);
    #1;
    chk(name, 64'(q.size()), 0);
  endtask

  task automatic set_vec(input int i, input int s0, input int s1, input int s2,
                         input int s3, input int s4, input int s5, input int s6,
                         input int mn, input int md, input int mx, input int ct,
                         input int nz);
    tbl[i].s[0] = DW'(s0); tbl[i].s[1] = DW'(s1); tbl[i].s[2] = DW'(s2);
    tbl[i].s[3] = DW'(s3); tbl[i].s[4] = DW'(s4); tbl[i].s[5] = DW'(s5);
    tbl[i].s[6] = DW'(s6);
    tbl[i].e = '{DW'(mn), DW'(md), DW'(mx), DW'(ct), nz != 0};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] sdata [14];
    int idx;
    bit acc;

    // samples listed in arrival order; center is the 4th sample
    set_vec(0, 1,2,3,4,5,6,7,            1,  4,  7,  4,  0);
    set_vec(1, 5,5,5,5,5,5,5,            5,  5,  5,  5,  0);
    set_vec(2, 10,10,10,255,10,10,10,   10, 10,255,255,  1);
    set_vec(3, 2,3,4,5,6,7,8,            2,  5,  8,  5,  0);
    set_vec(4, 7,6,5,4,3,2,1,            1,  4,  7,  4,  0);
    set_vec(5, 0,255,0,255,0,255,0,      0,  0,255,255,  1);
    set_vec(6, 100,100,100,132,100,100,100, 100,100,132,132, 0);
    set_vec(7, 100,100,100,133,100,100,100, 100,100,133,133, 1);
    set_vec(8, 100,100,100,67,100,100,100,   67,100,100, 67, 1);
    set_vec(9, 50,40,30,20,10,60,70,     10, 40, 70, 20, 0);

    repeat (3) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("reset_out_valid", 64'(out_valid), 0);
    chk("reset_in_ready",  64'(in_ready), 1);
    chk("reset_outputs", {out_min, out_med, out_max, out_center, 7'(out_noise)}, 0);
    @(posedge clk); #1;

    // Ramp 1..7 with latency check, then one more sample
    for (int v = 1; v <= 7; v++) send(DW'(v));
    @(negedge clk); chk("latency_c0", 64'(out_valid), 0);
    @(negedge clk); chk("latency_c1", 64'(out_valid), 0);
    @(negedge clk); chk("latency_c2", 64'(out_valid), 1);
    chk("ramp_med", 64'(out_med), 4);
    @(posedge clk); #1;
    send(8'd8);
    drain("ramp_drain");

    // Table vectors, each from a flushed window
    for (int t = 0; t < 10; t++) begin
      pulse_flush();
      tbl_mode = 1;
      tbl_exp = tbl[t].e;
      for (int k = 0; k < W; k++) send(tbl[t].s[k]);
      tbl_mode = 0;
      drain("table_drain");
    end

    // Continuous stream with a 3-cycle downstream stall
    pulse_flush();
    for (int k = 0; k < 14; k++) sdata[k] = DW'($urandom_range(0, 255));
    stall_seen = 0;
    idx = 0;
    for (int c = 0; c < 40; c++) begin
      in_valid  = idx < 14;
      in_data   = sdata[idx % 14];
      out_ready = !(c >= 10 && c < 13);
      @(negedge clk);
      acc = in_valid && in_ready;
      @(posedge clk);
      #1;
      if (acc) idx++;
    end
    in_valid = 0; out_ready = 1;
    chk("stall_all_accepted", 64'(idx), 14);
    chk("stall_cycles_seen", 64'(stall_seen >= 3), 1);
    drain("stall_drain");

    // Flush after 4 samples, refill with 6: nothing may come out
    pulse_flush();
    for (int k = 0; k < 4; k++) send(8'd200);
    pulse_flush();
    for (int k = 0; k < 6; k++) send(DW'(30 + 7 * k));
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("post_flush_quiet", 64'(out_valid), 0);
    end
    @(posedge clk); #1;
    send(8'd3);
    drain("post_flush_drain");

    // Reset with two results in flight
    pulse_flush();
    for (int v = 1; v <= 9; v++) send(DW'(v * 3));
    rst = 1;
    @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("midrst_out_valid", 64'(out_valid), 0);
    chk("midrst_in_ready", 64'(in_ready), 1);
    chk("midrst_outputs", {out_min, out_med, out_max, out_center, 7'(out_noise)}, 0);
    @(posedge clk); #1;
    for (int v = 1; v <= 6; v++) send(DW'(v));
    repeat (4) begin
      @(negedge clk);
      chk("midrst_refill_quiet", 64'(out_valid), 0);
    end
    @(posedge clk); #1;
    send(8'd7);
    drain("midrst_drain");

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
